fp_add_pipe: RTL and testbench

- Parametrised, 3-stage pipelined IEEE-754 binary floating-point adder/subtractor for the Vector ALU.
- Supersedes the combinational single-precision adder with:
  - a configurable format,
  - a subtract mode,
  - round-to-nearest-even,
  - full special-value handling,
  - exception flags,
  - a valid/ready handshake with backpressure.
- One result per cycle at full throughput. Sits between VALU operand collection and the writeback arbiter.

---
 rtl/fp_add_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_fp_add_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_pipe.sv
// Three-stage pipelined IEEE-754 adder/subtractor: unpack/align, add, normalise/round.
// Subnormals flush to zero on input and output; rounding is nearest-even.
module fp_add_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    op_sub,
  input  logic [EXP_W+FRAC_W:0]   a,
  input  logic [EXP_W+FRAC_W:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic [3:0]              flags
);
  localparam int W   = 1 + EXP_W + FRAC_W;
  localparam int AW  = FRAC_W + 4;           // hidden + fraction + guard/round/sticky
  localparam int LZW = $clog2(AW + 1);
  localparam logic [EXP_W-1:0]        EXP_ONES = '1;
  localparam logic [EXP_W:0]          AW_E     = (EXP_W+1)'(AW);
  localparam logic signed [EXP_W+1:0] E_ZERO   = '0;
  localparam logic signed [EXP_W+1:0] E_MAX    = {2'b00, EXP_ONES};
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

  logic adv;
  logic out_valid_reg;
  logic [W-1:0] result_reg;
  logic [3:0]   flags_reg;

  assign adv       = !out_valid_reg || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign flags     = flags_reg;

  // ---------------- stage 1: classify, swap, align ----------------
  logic              sa, sb, eff_sub;
  logic [EXP_W-1:0]  ea, eb, ea_z, eb_z;
  logic [FRAC_W-1:0] fa, fb;
  logic              a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
  logic [W-2:0]      mag_a, mag_b;
  logic [FRAC_W:0]   ma, mb;
  logic              swap;

  assign sa      = a[W-1];
  assign sb      = b[W-1] ^ op_sub;
  assign eff_sub = sa ^ sb;
  assign ea      = a[W-2:FRAC_W];
  assign eb      = b[W-2:FRAC_W];
  assign fa      = a[FRAC_W-1:0];
  assign fb      = b[FRAC_W-1:0];
  assign a_zero  = (ea == '0);
  assign b_zero  = (eb == '0);
  assign a_nan   = (ea == EXP_ONES) && (fa != '0);
  assign b_nan   = (eb == EXP_ONES) && (fb != '0);
  assign a_inf   = (ea == EXP_ONES) && (fa == '0);
  assign b_inf   = (eb == EXP_ONES) && (fb == '0);
  assign ea_z    = a_zero ? '0 : ea;
  assign eb_z    = b_zero ? '0 : eb;
  assign ma      = a_zero ? '0 : {1'b1, fa};
  assign mb      = b_zero ? '0 : {1'b1, fb};
  assign mag_a   = a_zero ? '0 : a[W-2:0];
  assign mag_b   = b_zero ? '0 : b[W-2:0];
  assign swap    = mag_b > mag_a;

  logic              s1_sign_next;
  logic [EXP_W-1:0]  el, es, diff;
  logic [FRAC_W:0]   ml, ms;
  logic [AW-1:0]     ext, mask, ml_ext, ms_aligned;
  logic              spec_next, spec_inv_next;
  logic [W-1:0]      spec_res_next;

  always_comb begin
    s1_sign_next = swap ? sb : sa;
    el           = swap ? eb_z : ea_z;
    es           = swap ? ea_z : eb_z;
    ml           = swap ? mb : ma;
    ms           = swap ? ma : mb;
    diff         = el - es;
    ml_ext       = {ml, 3'b000};
    ext          = {ms, 3'b000};
    mask         = ~({AW{1'b1}} << diff);
    if ({1'b0, diff} >= AW_E) begin
      ms_aligned = {{(AW-1){1'b0}}, |ms};
    end else begin
      ms_aligned = (ext >> diff) | {{(AW-1){1'b0}}, |(ext & mask)};
    end

    spec_next     = a_nan || b_nan || a_inf || b_inf;
    spec_inv_next = 1'b0;
    spec_res_next = QNAN;
    if (a_nan || b_nan) begin
      spec_res_next = QNAN;
    end else if (a_inf && b_inf) begin
      if (sa != sb) spec_inv_next = 1'b1;
      else          spec_res_next = {sa, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (a_inf) begin
      spec_res_next = {sa, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (b_inf) begin
      spec_res_next = {sb, EXP_ONES, {FRAC_W{1'b0}}};
    end
  end

  logic              s1_valid_reg, s1_spec_reg, s1_spec_inv_reg, s1_sign_reg, s1_sub_reg;
  logic [W-1:0]      s1_spec_res_reg;
  logic [EXP_W-1:0]  s1_exp_reg;
  logic [AW-1:0]     s1_ml_reg, s1_ms_reg;

  // ---------------- stage 2: add / subtract ----------------
  logic [AW:0] sum_next;
  logic        s2_sign_next;

  always_comb begin
    if (s1_sub_reg) sum_next = {1'b0, s1_ml_reg} - {1'b0, s1_ms_reg};
    else            sum_next = {1'b0, s1_ml_reg} + {1'b0, s1_ms_reg};
    // exact cancellation yields +0; like-signed zeros keep their sign
    s2_sign_next = (s1_sub_reg && (sum_next == '0)) ? 1'b0 : s1_sign_reg;
  end

  logic              s2_valid_reg, s2_spec_reg, s2_spec_inv_reg, s2_sign_reg;
  logic [W-1:0]      s2_spec_res_reg;
  logic [EXP_W-1:0]  s2_exp_reg;
  logic [AW:0]       s2_sum_reg;

  // ---------------- stage 3: normalise, round, pack ----------------
  logic                    carry, g, rs, rnd_up, inexact;
  logic [LZW-1:0]          lz, lz_eff;
  logic [AW-1:0]           norm;
  logic [FRAC_W+1:0]       mant_r;
  logic [FRAC_W-1:0]       frac_fin;
  logic signed [EXP_W+1:0] e_norm, e_fin;
  logic [W-1:0]            res_next;
  logic [3:0]              flg_next;

  always_comb begin
    carry = s2_sum_reg[AW];
    lz    = '0;
    for (int i = 0; i < AW; i++) begin
      if (s2_sum_reg[i]) lz = LZW'(AW - 1 - i);
    end
    lz_eff = carry ? '0 : lz;
    if (carry) norm = {s2_sum_reg[AW:2], |s2_sum_reg[1:0]};
    else       norm = s2_sum_reg[AW-1:0] << lz;
    e_norm = $signed({2'b00, s2_exp_reg}) + $signed({{(EXP_W+1){1'b0}}, carry})
           - $signed({{(EXP_W+2-LZW){1'b0}}, lz_eff});

    g       = norm[2];
    rs      = |norm[1:0];
    rnd_up  = g && (rs || norm[3]);
    inexact = g || rs;
    mant_r  = {1'b0, norm[AW-1:3]} + {{(FRAC_W+1){1'b0}}, rnd_up};
    e_fin   = e_norm + $signed({{(EXP_W+1){1'b0}}, mant_r[FRAC_W+1]});
    frac_fin = mant_r[FRAC_W+1] ? mant_r[FRAC_W:1] : mant_r[FRAC_W-1:0];

    res_next = {s2_sign_reg, e_fin[EXP_W-1:0], frac_fin};
    flg_next = {3'b000, inexact};
    if (s2_spec_reg) begin
      res_next = s2_spec_res_reg;
      flg_next = {s2_spec_inv_reg, 3'b000};
    end else if (s2_sum_reg == '0) begin
      res_next = {s2_sign_reg, {(W-1){1'b0}}};
      flg_next = 4'b0000;
    end else if (e_fin >= E_MAX) begin
      res_next = {s2_sign_reg, EXP_ONES, {FRAC_W{1'b0}}};
      flg_next = 4'b0101;
    end else if (e_fin <= E_ZERO) begin
      res_next = {s2_sign_reg, {(W-1){1'b0}}};
      flg_next = 4'b0011;
    end
  end

  // all stages move together; a stalled output freezes the whole pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg    <= 1'b0;
      s1_spec_reg     <= 1'b0;
      s1_spec_inv_reg <= 1'b0;
      s1_sign_reg     <= 1'b0;
      s1_sub_reg      <= 1'b0;
      s1_spec_res_reg <= '0;
      s1_exp_reg      <= '0;
      s1_ml_reg       <= '0;
      s1_ms_reg       <= '0;
      s2_valid_reg    <= 1'b0;
      s2_spec_reg     <= 1'b0;
      s2_spec_inv_reg <= 1'b0;
      s2_sign_reg     <= 1'b0;
      s2_spec_res_reg <= '0;
      s2_exp_reg      <= '0;
      s2_sum_reg      <= '0;
      out_valid_reg   <= 1'b0;
      result_reg      <= '0;
      flags_reg       <= '0;
    end else if (adv) begin
      s1_valid_reg    <= in_valid;
      s1_spec_reg     <= spec_next;
      s1_spec_inv_reg <= spec_inv_next;
      s1_sign_reg     <= s1_sign_next;
      s1_sub_reg      <= eff_sub;
      s1_spec_res_reg <= spec_res_next;
      s1_exp_reg      <= el;
      s1_ml_reg       <= ml_ext;
      s1_ms_reg       <= ms_aligned;
      s2_valid_reg    <= s1_valid_reg;
      s2_spec_reg     <= s1_spec_reg;
      s2_spec_inv_reg <= s1_spec_inv_reg;
      s2_sign_reg     <= s2_sign_next;
      s2_spec_res_reg <= s1_spec_res_reg;
      s2_exp_reg      <= s1_exp_reg;
      s2_sum_reg      <= sum_next;
      out_valid_reg   <= s2_valid_reg;
      if (s2_valid_reg) begin
        result_reg <= res_next;
        flags_reg  <= flg_next;
      end
    end
  end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe: FP32 directed vectors, backpressure, reset flush,
// plus a single FP16 sanity vector on a second instance.
module tb_fp_add_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;

  logic        h_in_valid, h_in_ready, h_op_sub, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_result;
  logic [3:0]  h_flags;

  fp_add_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  fp_add_pipe #(.EXP_W(5), .FRAC_W(10)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready), .op_sub(h_op_sub),
    .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready), .result(h_result),
    .flags(h_flags)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_out = 0;
  bit chk_lat = 1'b1;
  logic [35:0] exp_q[$];
  int          acc_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [35:0] obs, input logic [35:0] req);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, req);
    end
  endtask

  // offer one operation at posedge+1, hold until accepted, record the expectation
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                      input logic [31:0] er, input logic [3:0] ef);
    int  waited = 0;
    bit  done   = 1'b0;
    a = ta; b = tb_v; op_sub = ts; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({er, ef});
        acc_q.push_back(cyc + 1);
        done = 1'b1;
      end else if (++waited > 200) begin
        check_eq("in_ready_timeout", 36'h0, 36'h1);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq(tag, 36'(exp_q.size()), 36'h0);
    @(posedge clk); #1;
  endtask

  // output monitor: pops the scoreboard and checks stall stability
  initial begin
    logic [35:0] e, held;
    int          c;
    bit          stall_prev;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && out_valid)
          check_eq("hold_stable", {result, flags}, held);
        if (out_valid && out_ready) begin
          $display("[%0d] out result=%h flags=%b", cyc, result, flags);
          if (exp_q.size() == 0) begin
            check_eq("spurious_output", 36'h1, 36'h0);
          end else begin
            e = exp_q.pop_front();
            c = acc_q.pop_front();
            check_eq("result", {4'h0, result}, {4'h0, e[35:4]});
            check_eq("flags", {32'h0, flags}, {32'h0, e[3:0]});
            if (chk_lat) check_eq("latency", 36'(cyc + 1 - c), 36'd3);
            n_out++;
          end
        end
        stall_prev = out_valid && !out_ready;
        held       = {result, flags};
      end
    end
  end

  localparam int NV = 18;
  logic [31:0] tv_a [NV] = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h3F800000,
                             32'h3F800000, 32'h7F800000, 32'h7F7FFFFF, 32'h7FA00000,
                             32'h40400000, 32'h3F800000, 32'h00400000, 32'h3F800000,
                             32'h00800000, 32'h3F800000, 32'h3F800000, 32'h3F800001,
                             32'hFF800000, 32'h7F800000};
  logic [31:0] tv_b [NV] = '{32'h40000000, 32'h3F800000, 32'h00000000, 32'h33800000,
                             32'h34000000, 32'hFF800000, 32'h7F7FFFFF, 32'h3F800000,
                             32'h3F800000, 32'hBF000000, 32'h3F800000, 32'hFF800000,
                             32'h00C00000, 32'h30800000, 32'h33C00000, 32'h33800000,
                             32'hFF800000, 32'h7F800000};
  logic        tv_s [NV] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                             1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] tv_r [NV] = '{32'h40400000, 32'h00000000, 32'h80000000, 32'h3F800000,
                             32'h3F800001, 32'h7FC00000, 32'h7F800000, 32'h7FC00000,
                             32'h40000000, 32'h3F000000, 32'h3F800000, 32'hFF800000,
                             32'h80000000, 32'h3F800000, 32'h3F800001, 32'h3F800002,
                             32'hFF800000, 32'h7FC00000};
  logic [3:0]  tv_f [NV] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h8, 4'h5, 4'h0, 4'h0,
                             4'h0, 4'h0, 4'h0, 4'h3, 4'h1, 4'h1, 4'h1, 4'h0, 4'h8};

  initial begin
    int n0, hk;
    bit got;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_a = '0; h_b = '0; h_op_sub = 1'b0; h_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 36'(out_valid), 36'h0);
    check_eq("rst_result", {4'h0, result}, 36'h0);
    check_eq("rst_flags", 36'(flags), 36'h0);
    check_eq("rst_in_ready", 36'(in_ready), 36'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed vectors, back to back, consumer always ready
    for (int i = 0; i < NV; i++) send(tv_a[i], tv_b[i], tv_s[i], tv_r[i], tv_f[i]);
    drain("drain_directed");

    // backpressure: five ops, consumer stalls for seven cycles
    chk_lat = 1'b0;
    n0 = n_out;
    fork
      begin
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0);
        send(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'h0);
        send(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'h0);
        send(32'h40800000, 32'h3F800000, 1'b0, 32'h40A00000, 4'h0);
        send(32'h40A00000, 32'h3F800000, 1'b0, 32'h40C00000, 4'h0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("bp_out_valid", 36'(out_valid), 36'h1);
        check_eq("bp_in_ready", 36'(in_ready), 36'h0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");
    check_eq("bp_count", 36'(n_out - n0), 36'd5);
    chk_lat = 1'b1;

    // reset with three operations in flight
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0);
    send(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'h0);
    send(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'h0);
    rst_n = 1'b0;
    #1;
    check_eq("flush_out_valid", 36'(out_valid), 36'h0);
    check_eq("flush_result", {4'h0, result}, 36'h0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_idle", 36'(out_valid), 36'h0);
    send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'h0);
    drain("drain_post_reset");

    // FP16 instance
    h_a = 16'h3C00; h_b = 16'h3C00; h_op_sub = 1'b0; h_in_valid = 1'b1;
    @(negedge clk);
    check_eq("h_in_ready", 36'(h_in_ready), 36'h1);
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    got = 1'b0;
    hk  = -1;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (h_out_valid) begin
        got = 1'b1;
        hk  = k;
      end
    end
    $display("[%0d] fp16 out result=%h flags=%b", cyc, h_result, h_flags);
    check_eq("h_out_seen", 36'(got), 36'h1);
    check_eq("h_latency", 36'(hk), 36'd2);
    check_eq("h_result", 36'(h_result), 36'h4000);
    check_eq("h_flags", 36'(h_flags), 36'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
